// File: rtl/serv_alu_seq.sv
// rtl/serv_alu_seq.sv - parallel operand driver and serial result collector for the bit-serial ALU
// Optional compare/init pass enabled by SERV_ALU_SEQ_CMP_EN.
module serv_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_rs1,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic             i_two_phase,
    output logic             o_rs1,
    output logic             o_op_b,
    output logic             o_en,
    output logic             o_init,
    output logic             o_cnt_done,
    input  logic             i_rd,
    input  logic             i_cmp,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_cmp,
    output logic             o_done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rs1;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_rdata;
    logic             r_done;
    logic             w_accept;
    logic             w_active;
    logic             w_last;

    assign w_accept   = i_valid && (r_state == IDLE);
    assign w_active   = (r_state == INIT) || (r_state == RUN);
    assign w_last     = w_active && (r_cnt == CW'(WIDTH - 1));
    assign o_cnt_done = w_last;
    assign o_rs1      = r_rs1[0];
    assign o_op_b     = r_op_b[0];
    assign o_rdata    = r_rdata;
    assign o_done     = r_done;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        o_ready = 1'b0;
        o_en    = 1'b0;
        o_init  = 1'b0;
        case (r_state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
`ifdef SERV_ALU_SEQ_CMP_EN
                    w_next = i_two_phase ? INIT : RUN;
`else
                    w_next = RUN;
`endif
                end
            end
            INIT: begin
`ifdef SERV_ALU_SEQ_CMP_EN
                o_init = 1'b1;
                if (w_last) begin
                    w_next = RUN;
                end
`else
                w_next = IDLE;
`endif
            end
            RUN: begin
                o_en = 1'b1;
                if (w_last) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Operands rotate rather than shift so a second pass sees them unchanged.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_rs1   <= '0;
            r_op_b  <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == RUN) && w_last;
            if (w_accept) begin
                r_rs1  <= i_rs1;
                r_op_b <= i_op_b;
                r_cnt  <= '0;
            end else if (w_active) begin
                r_rs1  <= {r_rs1[0], r_rs1[WIDTH-1:1]};
                r_op_b <= {r_op_b[0], r_op_b[WIDTH-1:1]};
                r_cnt  <= r_cnt + CW'(1);
            end
            if (r_state == RUN) begin
                r_rdata <= {i_rd, r_rdata[WIDTH-1:1]};
            end
        end
    end

`ifdef SERV_ALU_SEQ_CMP_EN
    logic r_cmp;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_cmp <= 1'b0;
        end else if ((r_state == INIT) && w_last) begin
            r_cmp <= i_cmp;
        end
    end

    assign o_cmp = r_cmp;
`else
    logic w_unused;

    assign w_unused = i_two_phase ^ i_cmp;
    assign o_cmp    = 1'b0;
`endif

endmodule

// File: tb/tb_serv_alu_seq.sv
// tb/tb_serv_alu_seq.sv - directed self-checking bench for serv_alu_seq
module tb_serv_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         i_rst;
    logic         i_valid;
    logic         i_two_phase;
    logic         i_rd;
    logic         i_cmp;
    logic [W-1:0] i_rs1;
    logic [W-1:0] i_op_b;
    logic         o_ready;
    logic         o_rs1;
    logic         o_op_b;
    logic         o_en;
    logic         o_init;
    logic         o_cnt_done;
    logic         o_cmp;
    logic         o_done;
    logic [W-1:0] o_rdata;

    int   checks   = 0;
    int   failures = 0;
    logic carry    = 1'b0;
    logic exp_cmp  = 1'b0;

    serv_alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_rs1      (i_rs1),
        .i_op_b     (i_op_b),
        .i_two_phase(i_two_phase),
        .o_rs1      (o_rs1),
        .o_op_b     (o_op_b),
        .o_en       (o_en),
        .o_init     (o_init),
        .o_cnt_done (o_cnt_done),
        .i_rd       (i_rd),
        .i_cmp      (i_cmp),
        .o_rdata    (o_rdata),
        .o_cmp      (o_cmp),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serial ripple adder standing in for the ALU, fed from the DUT operand streams.
    task automatic alu_add_cycle();
        i_rd  = o_rs1 ^ o_op_b ^ carry;
        carry = (o_rs1 & o_op_b) | (carry & (o_rs1 ^ o_op_b));
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_valid = 1'b0; i_two_phase = 1'b0; i_rd = 1'b0; i_cmp = 1'b0;
        i_rs1 = '0; i_op_b = '0;
        tick();
        tick();
        i_rst = 1'b0;
        checks++;
        if ({o_ready, o_en, o_init, o_done, o_cnt_done, o_rs1, o_op_b, o_cmp} !== 8'b1000_0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=10000000",
                     {o_ready, o_en, o_init, o_done, o_cnt_done, o_rs1, o_op_b, o_cmp});
        end
        checks++;
        if (o_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata got=%h want=00000000", o_rdata);
        end
    endtask

    task automatic test_add_single();
        i_rs1 = 32'd5; i_op_b = 32'd7; i_two_phase = 1'b0; i_valid = 1'b1; carry = 1'b0;
        tick();
        i_valid = 1'b0;
        for (int i = 1; i <= W; i++) begin
            checks++;
            if ({o_en, o_init, o_cnt_done, o_ready, o_done} !== {1'b1, 1'b0, (i == W), 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL add_cycle%0d got=%b want=%b", i,
                         {o_en, o_init, o_cnt_done, o_ready, o_done}, {1'b1, 1'b0, (i == W), 1'b0, 1'b0});
            end
            alu_add_cycle();
            tick();
        end
        i_rd = 1'b0;
        checks++;
        if ({o_done, o_ready, o_en} !== 3'b110 || o_rdata !== 32'h0000000C) begin
            failures++;
            $display("FAIL add_done got=%b/%h want=110/0000000c", {o_done, o_ready, o_en}, o_rdata);
        end
        tick();
        checks++;
        if (o_done !== 1'b0) begin
            failures++;
            $display("FAIL add_done_pulse got=%b want=0", o_done);
        end
    endtask

    task automatic test_bit_order();
        i_rs1 = 32'h8000_0001; i_op_b = 32'h0000_0002; i_two_phase = 1'b0; i_valid = 1'b1; carry = 1'b0;
        tick();
        i_valid = 1'b0;
        for (int i = 1; i <= W; i++) begin
            checks++;
            if ({o_rs1, o_op_b} !== {(i == 1 || i == W), (i == 2)}) begin
                failures++;
                $display("FAIL bitorder_cycle%0d got=%b want=%b", i, {o_rs1, o_op_b},
                         {(i == 1 || i == W), (i == 2)});
            end
            alu_add_cycle();
            tick();
        end
        i_rd = 1'b0;
        checks++;
        if (o_done !== 1'b1 || o_rdata !== 32'h8000_0003) begin
            failures++;
            $display("FAIL bitorder_result got=%b/%h want=1/80000003", o_done, o_rdata);
        end
    endtask

`ifdef SERV_ALU_SEQ_CMP_EN
    task automatic test_two_phase();
        logic [W:1] a_bits;
        logic [W:1] b_bits;
        i_rs1 = 32'hFFFF_FFFF; i_op_b = 32'h0000_0001; i_two_phase = 1'b1; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        for (int i = 1; i <= W; i++) begin
            checks++;
            if ({o_en, o_init, o_cnt_done, o_done} !== {1'b0, 1'b1, (i == W), 1'b0}) begin
                failures++;
                $display("FAIL init_cycle%0d got=%b want=%b", i, {o_en, o_init, o_cnt_done, o_done},
                         {1'b0, 1'b1, (i == W), 1'b0});
            end
            a_bits[i] = o_rs1;
            b_bits[i] = o_op_b;
            i_cmp = (i == W);
            tick();
        end
        i_cmp = 1'b0;
        checks++;
        if (o_cmp !== 1'b1) begin
            failures++;
            $display("FAIL cmp_capture got=%b want=1", o_cmp);
        end
        for (int i = 1; i <= W; i++) begin
            checks++;
            if ({o_en, o_init, o_cnt_done, o_done, o_rs1, o_op_b} !==
                {1'b1, 1'b0, (i == W), 1'b0, a_bits[i], b_bits[i]}) begin
                failures++;
                $display("FAIL run2_cycle%0d got=%b want=%b", i,
                         {o_en, o_init, o_cnt_done, o_done, o_rs1, o_op_b},
                         {1'b1, 1'b0, (i == W), 1'b0, a_bits[i], b_bits[i]});
            end
            i_rd = (i == 1);
            tick();
        end
        i_rd = 1'b0;
        checks++;
        if (o_done !== 1'b1 || o_rdata !== 32'h0000_0001 || o_cmp !== 1'b1) begin
            failures++;
            $display("FAIL two_phase_done got=%b/%h/%b want=1/00000001/1", o_done, o_rdata, o_cmp);
        end
        exp_cmp = 1'b1;
        i_two_phase = 1'b0;
    endtask
`else
    task automatic test_two_phase_ignored();
        i_rs1 = 32'd3; i_op_b = 32'd4; i_two_phase = 1'b1; i_cmp = 1'b1; i_valid = 1'b1; carry = 1'b0;
        tick();
        i_valid = 1'b0;
        for (int i = 1; i <= W; i++) begin
            checks++;
            if ({o_en, o_init, o_cnt_done, o_done, o_cmp} !== {1'b1, 1'b0, (i == W), 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL nocmp_cycle%0d got=%b want=%b", i, {o_en, o_init, o_cnt_done, o_done, o_cmp},
                         {1'b1, 1'b0, (i == W), 1'b0, 1'b0});
            end
            alu_add_cycle();
            tick();
        end
        i_rd = 1'b0; i_cmp = 1'b0; i_two_phase = 1'b0;
        checks++;
        if (o_done !== 1'b1 || o_rdata !== 32'd7 || o_cmp !== 1'b0) begin
            failures++;
            $display("FAIL nocmp_done got=%b/%h/%b want=1/00000007/0", o_done, o_rdata, o_cmp);
        end
    endtask
`endif

    task automatic test_back_to_back();
        i_rs1 = 32'd10; i_op_b = 32'd20; i_two_phase = 1'b0; i_valid = 1'b1; carry = 1'b0;
        tick();
        i_rs1 = 32'd100; i_op_b = 32'd200;
        for (int i = 1; i <= W; i++) begin
            checks++;
            if ({o_en, o_ready, o_done, o_cnt_done} !== {1'b1, 1'b0, 1'b0, (i == W)}) begin
                failures++;
                $display("FAIL busy_cycle%0d got=%b want=%b", i, {o_en, o_ready, o_done, o_cnt_done},
                         {1'b1, 1'b0, 1'b0, (i == W)});
            end
            alu_add_cycle();
            tick();
        end
        i_rd = 1'b0;
        checks++;
        if ({o_done, o_ready} !== 2'b11 || o_rdata !== 32'd30 || o_cmp !== exp_cmp) begin
            failures++;
            $display("FAIL b2b_first got=%b/%h/%b want=11/0000001e/%b", {o_done, o_ready}, o_rdata, o_cmp, exp_cmp);
        end
        carry = 1'b0;
        tick();
        i_valid = 1'b0;
        for (int i = 1; i <= W; i++) begin
            checks++;
            if ({o_en, o_done, o_cnt_done} !== {1'b1, 1'b0, (i == W)}) begin
                failures++;
                $display("FAIL b2b_cycle%0d got=%b want=%b", i, {o_en, o_done, o_cnt_done},
                         {1'b1, 1'b0, (i == W)});
            end
            alu_add_cycle();
            tick();
        end
        i_rd = 1'b0;
        checks++;
        if (o_done !== 1'b1 || o_rdata !== 32'd300) begin
            failures++;
            $display("FAIL b2b_second got=%b/%h want=1/0000012c", o_done, o_rdata);
        end
    endtask

    task automatic test_reset_mid();
        logic seen_done;
        i_rs1 = 32'd1; i_op_b = 32'd2; i_two_phase = 1'b1; i_valid = 1'b1; carry = 1'b0;
        tick();
        i_valid = 1'b0; i_two_phase = 1'b0;
        for (int i = 1; i < 10; i++) begin
            alu_add_cycle();
            tick();
        end
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_rd = 1'b0;
        exp_cmp = 1'b0;
        checks++;
        if ({o_ready, o_en, o_init, o_done, o_cnt_done} !== 5'b10000 || o_rdata !== 32'h0 || o_cmp !== 1'b0) begin
            failures++;
            $display("FAIL midreset got=%b/%h/%b want=10000/00000000/0",
                     {o_ready, o_en, o_init, o_done, o_cnt_done}, o_rdata, o_cmp);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen_done |= o_done;
            tick();
        end
        checks++;
        if (seen_done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_no_done got=%b want=0", seen_done);
        end
    endtask

    initial begin
        test_reset();
        test_add_single();
        test_bit_order();
`ifdef SERV_ALU_SEQ_CMP_EN
        test_two_phase();
`else
        test_two_phase_ignored();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serv_alu_seq.md
Name: serv_alu_seq

Overview:
- Parallel-side driver and collector for the bit-serial ALU.
- Accepts two 32-bit operands, shifts them out LSB-first as the serial operand streams, and generates the enable, init and count-done strobes.
- Deserializes the serial result back into a parallel word.
- Used by the unit-test harness and by the multi-cycle coprocessor path that needs word-level access to the serial ALU.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, at least 4.

Ports:
- clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_valid  in  1  operand word pair valid
- o_ready  out  1  block idle, can accept operands
- i_rs1  in  WIDTH  parallel operand A
- i_op_b  in  WIDTH  parallel operand B
- i_two_phase  in  1  run an init (compare) pass before the execute pass
- o_rs1  out  1  serial operand A, LSB first
- o_op_b  out  1  serial operand B, LSB first
- o_en  out  1  execute-pass enable
- o_init  out  1  init-pass strobe
- o_cnt_done  out  1  last bit of the current pass
- i_rd  in  1  serial result from the ALU
- i_cmp  in  1  compare result from the ALU
- o_rdata  out  WIDTH  parallel result
- o_cmp  out  1  captured compare result
- o_done  out  1  one-cycle pulse, o_rdata valid

Behaviour:
- Reset: state IDLE. o_ready=1. All other outputs 0. Bit counter 0. Operand and result shift registers cleared.
- States: IDLE, INIT, RUN.
- Accept: the handshake i_valid & o_ready in cycle T loads i_rs1 and i_op_b into rotating shift registers and latches i_two_phase. i_valid while not IDLE is ignored.
- Next state after accept: INIT if the latched i_two_phase is 1, else RUN.
- o_ready is 1 only in IDLE.
- Serial output:
  - o_rs1 and o_op_b are bit 0 of the shift registers; combinational from state registers, no combinational path from inputs.
  - Registers rotate right by one every INIT or RUN cycle, so after WIDTH cycles the operands are restored for the next pass.
- Counter: log2(WIDTH) bits. Cleared on accept; increments each INIT or RUN cycle and wraps to 0 at the end of a pass.
- o_cnt_done = (count == WIDTH-1) while in INIT or RUN.
- INIT:
  - o_init=1, o_en=0.
  - On the cycle with o_cnt_done, i_cmp is sampled into o_cmp and the state becomes RUN.
- RUN:
  - o_en=1, o_init=0.
  - Each cycle i_rd is shifted into the MSB of o_rdata, with the register shifting right; after WIDTH cycles bit 0 holds the first result bit.
  - On o_cnt_done the state becomes IDLE and o_done is set for the following cycle.
- Latency:
  - Single-phase: bits presented T+1..T+WIDTH; o_done=1 and o_ready=1 at T+WIDTH+1.
  - Two-phase: init pass T+1..T+WIDTH, run pass T+WIDTH+1..T+2*WIDTH; o_done at T+2*WIDTH+1.
- Back-to-back: an accept is legal in the same cycle o_done is high; the new operation then starts at the next cycle with the same timing.
- Hold: o_rdata and o_cmp hold their values until the RUN, respectively INIT, pass of the next operation modifies them. o_cmp is not cleared by accept.
- Reset mid-operation: i_rst in any state returns to IDLE with reset values on the next edge. No o_done is generated for the aborted operation.
- Exclusivity: o_en and o_init are never high in the same cycle. o_done never coincides with o_en.

Optional Feature:
- Macro: SERV_ALU_SEQ_CMP_EN.
- Defined: behaviour as above (INIT state, i_two_phase honoured, o_cmp captured).
- Undefined:
  - INIT state, o_cmp register and i_cmp sampling are removed.
  - i_two_phase is ignored; every accept goes straight to RUN.
  - o_init and o_cmp are tied 0.
  - The port list is unchanged.

Test Plan:
- Add, single-phase: rs1=5, op_b=7, ALU add, accept at T -> o_en high T+1..T+32, o_cnt_done only at T+32, o_done at T+33 with o_rdata=0x0000000C.
- Bit order: rs1=0x80000001, op_b=0x00000002 -> o_rs1 is 1 at T+1, 0 at T+2..T+31, 1 at T+32; o_op_b is 1 only at T+2.
- Two-phase signed compare: rs1=0xFFFFFFFF, op_b=1, slt -> o_init T+1..T+32, then o_en T+33..T+64, o_cmp=1 from T+33, o_done at T+65, operands re-presented identically in the second pass.
- Busy/back-to-back: i_valid held high with a new pair during RUN -> ignored; second pair accepted on the o_done cycle -> second o_done exactly 33 cycles later.
- Reset mid-op: i_rst at T+10 -> next cycle o_ready=1 and o_en/o_init/o_done=0; no o_done pulse afterwards.
- Macro undefined: i_two_phase=1 -> o_init never asserted, o_done at T+33, o_cmp stays 0.
